// File: rtl/counter_mod_updown.sv
// Parametrised up/down modulo counter with clear/load, wrap-or-saturate, tc pulse and sticky overflow.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module counter_mod_updown #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             ovf_sticky
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  generate
    if (WIDTH < 2 || MAX_VAL >= (1 << WIDTH) || PRESCALE < 2) begin : g_param_err
      $error("counter_mod_updown: illegal parameter combination");
    end
  endgenerate

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             at_end;

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned   PW    = $clog2(PRESCALE);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;

  // Phase restarts on clr/load so a fresh value always gets a full period.
  always_comb begin
    presc_d = presc_q;
    if (clr || load)
      presc_d = '0;
    else if (en)
      presc_d = (presc_q == PLAST) ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end

  assign step = en && (presc_q == PLAST);
`else
  assign step = en;
`endif

  assign at_end = up_dn ? (count_q == MAX) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > MAX) ? MAX : load_val;
    end else if (step) begin
      tc_d = at_end;
      if (at_end) begin
        if (!SATURATE) count_d = up_dn ? '0 : MAX;
      end else begin
        count_d = up_dn ? count_q + ONE : count_q - ONE;
      end
    end
    // A new end event outranks a same-cycle clear request.
    if (ovf_clr) ovf_d = 1'b0;
    if (tc_d)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_out  = count_q;
  assign tc         = tc_q;
  assign ovf_sticky = ovf_q;

endmodule
